// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU/load writeback requests and the register-file write port
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              AluValid;
   logic              AluReady;
   logic [0:ADDR_W-1] AluAddr;
   logic [0:DATA_W-1] AluData;
   logic              LdValid;
   logic              LdReady;
   logic [0:ADDR_W-1] LdAddr;
   logic [0:DATA_W-1] LdData;
   logic [0:1]        LdSize;
   logic              LdUnsigned;
   logic              Stall;
   logic              WrEn;
   logic [0:ADDR_W-1] WrAddr;
   logic [0:DATA_W-1] WrData;
   logic              LastGrant;
   modport master (
      output AluValid, AluAddr, AluData, LdValid, LdAddr, LdData, LdSize, LdUnsigned, Stall,
      input  AluReady, LdReady, WrEn, WrAddr, WrData, LastGrant
   );
   modport slave (
      input  AluValid, AluAddr, AluData, LdValid, LdAddr, LdData, LdSize, LdUnsigned, Stall,
      output AluReady, LdReady, WrEn, WrAddr, WrData, LastGrant
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port between ALU and load writeback
module regfile_wb_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 5,
   parameter int DROP_R0 = 1
) (
   input logic clk,
   input logic rst,
   regfile_wb_arbiter_if.slave bus
);
   logic              aluGo, ldGo, aluDrop, ldDrop, signB, signH;
   logic [0:DATA_W-1] ldExt;
   // gating with rst keeps X valids during reset away from the ready outputs
   assign bus.AluReady = ~rst & ~bus.Stall & bus.AluValid & (~bus.LdValid | bus.LastGrant);
   assign bus.LdReady  = ~rst & ~bus.Stall & bus.LdValid & (~bus.AluValid | ~bus.LastGrant);
   assign aluGo   = bus.AluValid & bus.AluReady;
   assign ldGo    = bus.LdValid & bus.LdReady;
   assign aluDrop = (DROP_R0 != 0) && (bus.AluAddr == '0);
   assign ldDrop  = (DROP_R0 != 0) && (bus.LdAddr == '0);
   always_comb begin
      signB = bus.LdData[DATA_W-8] & ~bus.LdUnsigned;
      signH = bus.LdData[DATA_W-16] & ~bus.LdUnsigned;
      ldExt = bus.LdSize == 2'b00 ? {{(DATA_W-8){signB}}, bus.LdData[DATA_W-8:DATA_W-1]} :
              bus.LdSize == 2'b01 ? {{(DATA_W-16){signH}}, bus.LdData[DATA_W-16:DATA_W-1]} :
              bus.LdData;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.WrEn      <= 1'b0;
         bus.WrAddr    <= '0;
         bus.WrData    <= '0;
         bus.LastGrant <= 1'b1;
      end else begin
         bus.WrEn <= (aluGo & ~aluDrop) | (ldGo & ~ldDrop);
         if (aluGo | ldGo) begin
            bus.WrAddr    <= aluGo ? bus.AluAddr : bus.LdAddr;
            bus.WrData    <= aluGo ? bus.AluData : ldExt;
            bus.LastGrant <= ldGo;
         end
      end
   end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback requesters: the ALU result path and the memory-load path. Load data is narrowed and sign- or zero-extended to 32 bits according to access size before the write. Arbitration is round-robin. The write port is driven from a registered output stage, so the block sits between the execute/memory stages and the register file.

Parameters:
DATA_W, 32, register data width; bit 0 is the MSB and bit DATA_W-1 is the LSB.
ADDR_W, 5, register address width.
DROP_R0, 1, when 1, writes to register 0 are accepted but never issued (WrEn stays 0).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
AluValid  in  1  ALU writeback request.
AluReady  out  1  ALU request accepted this cycle.
AluAddr  in  [0:ADDR_W-1]  ALU destination register.
AluData  in  [0:DATA_W-1]  ALU result.
LdValid  in  1  load writeback request.
LdReady  out  1  load request accepted this cycle.
LdAddr  in  [0:ADDR_W-1]  load destination register.
LdData  in  [0:DATA_W-1]  raw load word; the byte is at [24:31] and the half is at [16:31].
LdSize  in  [0:1]  00 = byte, 01 = half, 10 = word, 11 = word.
LdUnsigned  in  1  1 = zero-extend, 0 = sign-extend.
Stall  in  1  register file is unable to accept a write; no grants are issued.
WrEn  out  1  register-file write enable.
WrAddr  out  [0:ADDR_W-1]  register-file write address.
WrData  out  [0:DATA_W-1]  register-file write data.
LastGrant  out  1  0 = ALU granted last, 1 = load granted last.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - WrEn=0, WrAddr=0, WrData=0.
  - LastGrant=1, so the ALU wins the first tie.
  - While rst=1, AluReady=0 and LdReady=0.
- Ready signals are combinational from the current valid inputs, Stall and LastGrant:
  - Both ready outputs are 0 when Stall=1.
  - Only one valid: that requester's ready=1.
  - Both valid: the requester not granted last gets ready=1 and the other gets 0.
  - A transfer occurs on a cycle with valid=1 and ready=1; at most one transfer per cycle.
- Latency: a transfer in cycle N produces WrEn/WrAddr/WrData in cycle N+1, held for exactly one cycle.
  - With no transfer in cycle N, WrEn=0 in cycle N+1, and WrAddr/WrData hold their previous values.
- LastGrant updates on every transfer to the winning requester and is unchanged otherwise. This gives strict alternation under continuous contention.
- Load extension, computed combinationally and registered with the transfer:
  - Byte: {24{s}, LdData[24:31]}, where s = LdData[24] & ~LdUnsigned.
  - Half: {16{s}, LdData[16:31]}, where s = LdData[16] & ~LdUnsigned.
  - Word: LdData unchanged; LdUnsigned is ignored.
- ALU data passes through unmodified.
- Register 0 (DROP_R0=1): a transfer with address 0 completes (ready=1, LastGrant updates), but WrEn=0 in the next cycle.
- Stall is sampled only in the grant cycle; a write already registered still issues in the following cycle regardless of Stall.
- Requesters keep valid, address and data stable until accepted; the block does not buffer unaccepted requests.
- Reset mid-operation: a registered pending write is discarded (WrEn=0 in the cycle after reset), and arbitration state returns to its reset values.
- Valid inputs that are X/Z while rst=1 must not propagate to the outputs.

Test Plan:
- Single ALU write: AluValid=1, AluAddr=5, AluData=0x12345678 for one cycle -> AluReady=1 that cycle; next cycle WrEn=1, WrAddr=5, WrData=0x12345678; LastGrant=0.
- Load byte signed, then unsigned: LdData=0x000000F0, LdSize=00, LdUnsigned=0, LdAddr=7 -> WrData=0xFFFFFFF0. Repeat with LdUnsigned=1 -> WrData=0x000000F0.
- Load half signed, then word: LdData=0xABCD8001, LdSize=01, LdUnsigned=0 -> WrData=0xFFFF8001. Repeat with LdSize=10 -> WrData=0xABCD8001.
- Contention: both valid continuously for 4 cycles after reset -> grants in order ALU, Ld, ALU, Ld; WrEn=1 on each following cycle; ready is never 1 on both sides in the same cycle.
- Stall and register 0:
  - Stall=1 with both valid for 3 cycles -> both ready=0 and WrEn=0 throughout.
  - Release Stall with AluAddr=0 -> AluReady=1, WrEn stays 0, LastGrant=0.
- Reset mid-operation: assert rst in the cycle after an ALU transfer -> WrEn=0, WrAddr=0, WrData=0, LastGrant=1; first grant after reset under contention goes to ALU.
